// File: rtl/vm2_irq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vm2_irq_ctrl_if                                                  |
// | Brief   : Processor/peripheral-side signal bundle of the VM2 vectored IRQ  |
// |           controller (requests, vectors, strobe/acknowledge handshake).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface vm2_irq_ctrl_if #(
  parameter int N = 8
) ();
  logic [N-1:0]    ireq;
  logic [16*N-1:0] ivec_in;
  logic            istb;
  logic            virq;
  logic [15:0]     ivec;
  logic            iack;
  logic [N-1:0]    dev_ack;
  logic [3:0]      active;

  // Environment side: peripherals and the processor module together.
  modport master (
    output ireq, ivec_in, istb,
    input  virq, ivec, iack, dev_ack, active
  );

  modport slave (
    input  ireq, ivec_in, istb,
    output virq, ivec, iack, dev_ack, active
  );
endinterface
`default_nettype wire

// File: rtl/vm2_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vm2_irq_ctrl                                                     |
// | Brief   : Vectored interrupt controller, fixed priority (channel 0 first), |
// |           or rotating priority when VIC_ROUND_ROBIN_EN is defined.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vm2_irq_ctrl #(
  parameter int          N        = 8,
  parameter logic [15:0] SPUR_VEC = 16'o000
) (
  input wire            clk_p,
  input wire            rst,
  vm2_irq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LATCH   = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    ireq_q;
  logic [15:0]     ivec_q, ivec_d;
  logic [3:0]      active_q, active_d;
  logic            spur_q, spur_d;
  logic            iack_q, iack_d;
  logic [N-1:0]    dev_ack_q, dev_ack_d;

  logic            win_found;
  logic [3:0]      win_idx;
  logic [15:0]     win_vec;

`ifdef VIC_ROUND_ROBIN_EN
  logic [3:0]      ptr_q, ptr_d;

  function automatic int rr_slot(input logic [3:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return s;
  endfunction
`endif

  // Descending scan so the highest-priority candidate is the last one written.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_vec   = '0;
    for (int k = N - 1; k >= 0; k--) begin
`ifdef VIC_ROUND_ROBIN_EN
      if (ireq_q[rr_slot(ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = 4'(rr_slot(ptr_q, k));
        win_vec   = bus.ivec_in[16*rr_slot(ptr_q, k) +: 16];
      end
`else
      if (ireq_q[k]) begin
        win_found = 1'b1;
        win_idx   = 4'(k);
        win_vec   = bus.ivec_in[16*k +: 16];
      end
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ivec_d    = ivec_q;
    active_d  = active_q;
    spur_d    = spur_q;
    iack_d    = 1'b0;
    dev_ack_d = '0;
`ifdef VIC_ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.istb) state_d = S_LATCH;
      end
      S_LATCH: begin
        if (win_found) begin
          ivec_d   = {win_vec[15:1], 1'b0};
          active_d = win_idx;
          spur_d   = 1'b0;
        end else begin
          ivec_d   = SPUR_VEC;
          active_d = '0;
          spur_d   = 1'b1;
        end
        state_d = S_ACK;
      end
      S_ACK: begin
        // Outputs are registered, so iack lands a full cycle after ivec settles.
        iack_d = 1'b1;
        if (!spur_q) begin
          for (int i = 0; i < N; i++) dev_ack_d[i] = (active_q == 4'(i));
`ifdef VIC_ROUND_ROBIN_EN
          ptr_d = (active_q == 4'(N - 1)) ? 4'd0 : active_q + 4'd1;
`endif
        end
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (bus.istb) iack_d  = 1'b1;
        else          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ireq_q    <= '0;
      ivec_q    <= 16'o000;
      active_q  <= '0;
      spur_q    <= 1'b0;
      iack_q    <= 1'b0;
      dev_ack_q <= '0;
`ifdef VIC_ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ireq_q    <= bus.ireq;
      ivec_q    <= ivec_d;
      active_q  <= active_d;
      spur_q    <= spur_d;
      iack_q    <= iack_d;
      dev_ack_q <= dev_ack_d;
`ifdef VIC_ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  // virq is masked for the whole vector cycle so a request cannot re-enter.
  assign bus.virq    = (state_q == S_IDLE) && (|ireq_q);
  assign bus.ivec    = ivec_q;
  assign bus.iack    = iack_q;
  assign bus.dev_ack = dev_ack_q;
  assign bus.active  = active_q;

endmodule
`default_nettype wire

// File: doc/vm2_irq_ctrl.md
# vm2_irq_ctrl

Vectored interrupt controller for the VM2 processor board. It collects level interrupt requests from up to `N` peripheral channels and resolves priority. It drives the processor module's `virq` and `ivec` inputs and answers its `istb` vector-read strobe with `iack`. It also returns a one-cycle acknowledge pulse to the winning peripheral so that peripheral can drop its request. It sits directly upstream of the processor module, between it and the peripheral devices.

## Interface

Parameters:
- `N`, default 8: number of request channels, 1..16. Channel 0 has the highest fixed priority.
- `SPUR_VEC`, default 16'o000: vector returned when `istb` arrives with no request pending.

Ports:
- `clk_p`, in, 1: system clock. All logic is on the rising edge.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `ireq`, in, N: per-channel request levels. A channel holds its bit high until it receives `dev_ack`.
- `ivec_in`, in, 16*N: per-channel vectors. Channel i uses bits [16*i+15:16*i]. Bit 0 is ignored and forced to 0 on output.
- `virq`, out, 1: interrupt request to the processor.
- `ivec`, out, 16: registered vector to the processor.
- `istb`, in, 1: vector-read strobe from the processor (already gated against the startup-register read).
- `iack`, out, 1: vector acknowledge to the processor.
- `dev_ack`, out, N: one-hot, one-cycle acknowledge to the winning channel.
- `active`, out, 4: index of the channel latched in the current vector cycle. Used for debug and the bench.

## Operation

- **State machine:** `IDLE` → `LATCH` → `ACK` → `RELEASE` → `IDLE`.
- **`IDLE`:**
  - `virq` = OR of `ireq`, combinational from the registered `ireq_r`. Requests are registered once on input.
  - `iack` = 0; `dev_ack` = 0.
  - When `istb` is sampled high, go to `LATCH`.
- **`LATCH`:**
  - Select the winner from `ireq_r` (fixed priority, lowest index wins).
  - Register `ivec` ← winner's vector with bit 0 cleared, and `active` ← winner index.
  - If `ireq_r` = 0, register `ivec` ← `SPUR_VEC`, set `active` = 0, and set an internal `spur` flag.
  - Go to `ACK`.
- **`ACK`:**
  - `iack` = 1.
  - `dev_ack[active]` = 1 for exactly this cycle; suppressed when `spur` is set.
  - Go to `RELEASE`.
- **`RELEASE`:**
  - `iack` held at 1 while `istb` is high.
  - When `istb` is sampled low, `iack` goes to 0 and the state goes to `IDLE`.
- **`virq` outside `IDLE`:** forced to 0 in `LATCH`, `ACK` and `RELEASE`. This prevents re-entry on the same request before the device has dropped it.
- **Request changes after `LATCH`:** a request that drops after `LATCH` does not alter the latched vector. A new or higher-priority request arriving during a vector cycle waits for `IDLE`.
- **`ivec` retention:** `ivec` holds its value until the next `LATCH`.
- **Reset (asynchronous):**
  - State → `IDLE`.
  - `virq`, `iack`, `dev_ack`, `ireq_r` → 0.
  - `ivec` → 16'o000; `active` → 0; `spur` → 0.
- **Reset mid-cycle:** a reset during `LATCH`/`ACK`/`RELEASE` abandons the cycle with no `dev_ack` emitted after the reset edge.

## Timing

- `ireq` to `virq`: 1 cycle, through the `ireq_r` register.
- `istb` first sampled high at edge T:
  - state = `LATCH` after T;
  - `ivec` valid and `iack` = 1 after T+2 (`ACK`);
  - `dev_ack` pulse during the cycle after T+2 only.
- `iack` is asserted no earlier than one full cycle after `ivec` is stable, so the processor samples a settled vector.
- `istb` low sampled at edge R (state `RELEASE`): `iack` = 0 and state = `IDLE` after R.
  - `virq` may reassert in that same cycle if requests remain.
- **`istb` dropping early:** if `istb` drops during `LATCH` or `ACK`, the sequence still completes through `ACK` (including `dev_ack`). `RELEASE` then exits on the next edge.
- **Back-to-back cycles:** minimum 4 cycles per vector cycle. A second `istb` is honoured only from `IDLE`.

## Configuration

- Macro: `VIC_ROUND_ROBIN_EN`.
- **Defined:** rotating priority.
  - A pointer register (reset 0) names the highest-priority channel.
  - After each non-spurious `ACK`, the pointer ← (`active` + 1) mod N.
  - Selection searches upward from the pointer with wrap-around.
- **Undefined:** fixed priority, channel 0 highest. No pointer register is built.

## Test plan

- **Single request:** `ireq`=8'b0000_0100, channel 2 vector 16'o000064, `istb` pulsed 6 cycles → `virq` 1 cycle after `ireq`; `ivec`=16'o000064 and `iack`=1 at T+2; `dev_ack`=8'b0000_0100 for 1 cycle; `iack` falls 1 cycle after `istb`.
- **Fixed priority:** `ireq`=8'b1001_0010 with vectors 0o100, 0o104, … → first cycle returns channel 1's vector. After channel 1 drops, the next returns channel 4's, then channel 7's.
- **Spurious strobe:** `ireq`=0, `istb` pulse → `ivec`=`SPUR_VEC`, `iack` asserted, `dev_ack` stays 0.
- **Request withdrawn after latch:** `ireq[3]` drops in the `ACK` cycle → `ivec` keeps channel 3's vector, `dev_ack[3]` still pulses, `virq`=0 until `IDLE`.
- **Reset mid-cycle:** `rst` asserted in `RELEASE` → `iack`, `virq`, `dev_ack` go to 0 asynchronously, `ivec`=0, state `IDLE`. After release, a pending `ireq` raises `virq` after 1 cycle.
- **Round robin (`VIC_ROUND_ROBIN_EN`):** `ireq`=8'b0000_0011 held high for three cycles → winners in order 0, 1, 0.
